// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the data-memory response block.
// Holds the FSM state type and the word-index width derivation.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } mem_state_e;

    localparam int unsigned DepthDefault      = 64;
    localparam int unsigned WaitCyclesDefault = 2;
    localparam int unsigned WaitCntWidth      = 4;

    function automatic int unsigned idx_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// CPU data-port bus between the requester (master) and the memory (slave).
interface data_mem_resp_if;

    logic        MemRead;
    logic        MemWrite;
    logic [31:0] DataAddr;
    logic [31:0] WriteMem;
    logic [31:0] Memout;
    logic        MemReady;
    logic        MemErr;

    modport master (
        output MemRead, MemWrite, DataAddr, WriteMem,
        input  Memout, MemReady, MemErr
    );

    modport slave (
        input  MemRead, MemWrite, DataAddr, WriteMem,
        output Memout, MemReady, MemErr
    );

endinterface

// File: rtl/data_ram.sv
// Word storage: synchronous write port, combinational read port, no reset.
module data_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_resp.sv
// Wait-state data memory: accepts one request in idle, waits WAIT_CYCLES,
// then completes with a one-cycle MemReady pulse (MemErr on bad accesses).
module data_mem_resp
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = DepthDefault,
    parameter int unsigned WAIT_CYCLES = WaitCyclesDefault
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_resp_if.slave bus
);

    localparam int unsigned AW = idx_width(DEPTH);
    localparam logic [WaitCntWidth-1:0] WaitInit = WaitCntWidth'(WAIT_CYCLES);

    mem_state_e              state_q, state_d;
    logic [WaitCntWidth-1:0] cnt_q, cnt_d;
    logic [AW-1:0]           addr_q;
    logic [31:0]             wdata_q;
    logic                    wr_q;
    logic                    err_q;
    logic [31:0]             memout_q;

    logic          req;
    logic          accept;
    logic          go_done;
    logic          in_err;
    logic [AW-1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic          cur_wr;
    logic          cur_err;
    logic          ram_we;
    logic [31:0]   ram_rdata;

    assign req    = bus.MemRead | bus.MemWrite;
    assign accept = (state_q == StIdle) && req;
    assign in_err = (bus.DataAddr[1:0] != 2'b00)
                  | (bus.DataAddr[31:AW+2] != '0)
                  | (bus.MemRead & bus.MemWrite);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    cnt_d = WaitInit;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StDone;
                        go_done = 1'b1;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == 4'd1) begin
                    state_d = StDone;
                    go_done = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // With zero wait states completion happens on the accepting edge, so the
    // live bus values stand in for the not-yet-latched ones.
    always_comb begin
        cur_addr  = accept ? bus.DataAddr[AW+1:2] : addr_q;
        cur_wdata = accept ? bus.WriteMem : wdata_q;
        cur_wr    = accept ? bus.MemWrite : wr_q;
        cur_err   = accept ? in_err : err_q;
        ram_we    = go_done && cur_wr && !cur_err && rst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            memout_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= bus.DataAddr[AW+1:2];
                wdata_q <= bus.WriteMem;
                wr_q    <= bus.MemWrite;
                err_q   <= in_err;
            end
            if (go_done) begin
                if (cur_err) begin
                    memout_q <= '0;
                end else if (!cur_wr) begin
                    memout_q <= ram_rdata;
                end
            end
        end
    end

    data_ram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_data_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(cur_addr),
        .wdata(cur_wdata),
        .raddr(cur_addr),
        .rdata(ram_rdata)
    );

    assign bus.MemReady = (state_q == StDone);
    assign bus.MemErr   = (state_q == StDone) && err_q;
    assign bus.Memout   = memout_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench: one DUT with two wait states and one with none, sharing
// the same stimulus so every access is checked at both latencies.
module tb_data_mem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr, b_en;
    logic [31:0] addr, wdata;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    data_mem_resp_if ifa ();
    data_mem_resp_if ifb ();

    assign ifa.MemRead  = rd;
    assign ifa.MemWrite = wr;
    assign ifa.DataAddr = addr;
    assign ifa.WriteMem = wdata;
    assign ifb.MemRead  = rd & b_en;
    assign ifb.MemWrite = wr & b_en;
    assign ifb.DataAddr = addr;
    assign ifb.WriteMem = wdata;

    data_mem_resp #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut_a (
        .clk(clk),
        .rst(rst),
        .bus(ifa)
    );

    data_mem_resp #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk),
        .rst(rst),
        .bus(ifb)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; presents one request for exactly one rising edge.
    task automatic txn(input string tag, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_out, input logic exp_err);
        int          la, lb;
        logic [31:0] oa, ob;
        logic        ea, eb;
        la = 0; lb = 0; oa = '0; ob = '0; ea = 1'b0; eb = 1'b0;
        rd = r; wr = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ifa.MemReady && la == 0) begin
                la = n; oa = ifa.Memout; ea = ifa.MemErr;
            end
            if (ifb.MemReady && lb == 0) begin
                lb = n; ob = ifb.Memout; eb = ifb.MemErr;
            end
            if (la != 0 && (lb != 0 || !b_en)) break;
        end
        check_eq({tag, "_lat_a"}, 32'(la), 32'd3);
        check_eq({tag, "_out_a"}, oa, exp_out);
        check_eq({tag, "_err_a"}, {31'b0, ea}, {31'b0, exp_err});
        if (b_en) begin
            check_eq({tag, "_lat_b"}, 32'(lb), 32'd1);
            check_eq({tag, "_out_b"}, ob, exp_out);
            check_eq({tag, "_err_b"}, {31'b0, eb}, {31'b0, exp_err});
        end
        @(negedge clk);
        check_eq({tag, "_pulse_a"}, {31'b0, ifa.MemReady}, 32'd0);
    endtask

    initial begin
        int nr;
        int rpos[3];
        int extra;

        rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; b_en = 1'b1;
        #1;
        check_eq("rst_ready_a", {31'b0, ifa.MemReady}, 32'd0);
        check_eq("rst_err_a", {31'b0, ifa.MemErr}, 32'd0);
        check_eq("rst_out_a", ifa.Memout, 32'd0);
        check_eq("rst_out_b", ifb.Memout, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        txn("wr10",   1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 32'h0000_0000, 1'b0);
        txn("rd10",   1'b1, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0);
        txn("wrfc",   1'b0, 1'b1, 32'h0FC, 32'h11223344, 32'hDEADBEEF, 1'b0);
        txn("wr00",   1'b0, 1'b1, 32'h000, 32'h0BADF00D, 32'hDEADBEEF, 1'b0);
        txn("rd13",   1'b1, 1'b0, 32'h013, 32'h0,        32'h0000_0000, 1'b1);
        txn("wr100",  1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 32'h0000_0000, 1'b1);
        txn("rdfc",   1'b1, 1'b0, 32'h0FC, 32'h0,        32'h11223344, 1'b0);
        txn("rd00",   1'b1, 1'b0, 32'h000, 32'h0,        32'h0BADF00D, 1'b0);
        txn("wr08",   1'b0, 1'b1, 32'h008, 32'h08080808, 32'h0BADF00D, 1'b0);
        txn("both08", 1'b1, 1'b1, 32'h008, 32'hFFFFFFFF, 32'h0000_0000, 1'b1);
        txn("rd08",   1'b1, 1'b0, 32'h008, 32'h0,        32'h08080808, 1'b0);
        txn("wr20",   1'b0, 1'b1, 32'h020, 32'h11111111, 32'h08080808, 1'b0);
        txn("rd20",   1'b1, 1'b0, 32'h020, 32'h0,        32'h11111111, 1'b0);
        txn("wr04",   1'b0, 1'b1, 32'h004, 32'h12345678, 32'h11111111, 1'b0);
        txn("rd04",   1'b1, 1'b0, 32'h004, 32'h0,        32'h12345678, 1'b0);

        // Abort an uncommitted write by resetting while the slow DUT is busy.
        b_en = 1'b0;
        wr = 1'b1; addr = 32'h020; wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("abort_ready", {31'b0, ifa.MemReady}, 32'd0);
        check_eq("abort_err", {31'b0, ifa.MemErr}, 32'd0);
        check_eq("abort_out", ifa.Memout, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        extra = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (ifa.MemReady) extra++;
        end
        check_eq("abort_no_ready", 32'(extra), 32'd0);
        txn("rd20_after", 1'b1, 1'b0, 32'h020, 32'h0, 32'h11111111, 1'b0);

        // Strobe held high: three completions spaced WAIT_CYCLES+2 apart.
        nr = 0;
        rpos[0] = 0; rpos[1] = 0; rpos[2] = 0;
        extra = 0;
        rd = 1'b1; addr = 32'h0FC;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (ifa.MemReady) begin
                if (nr < 3) rpos[nr] = n;
                else extra++;
                nr++;
                check_eq("held_out", ifa.Memout, 32'h11223344);
            end
            if (n == 12) rd = 1'b0;
        end
        check_eq("held_count", 32'(nr), 32'd3);
        check_eq("held_pos0", 32'(rpos[0]), 32'd3);
        check_eq("held_pos1", 32'(rpos[1]), 32'd7);
        check_eq("held_pos2", 32'(rpos[2]), 32'd11);
        check_eq("held_extra", 32'(extra), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
